// File: rtl/osd_string_scheduler.sv
// osd_string_scheduler
// Purpose : round-robin arbiter for OSD text-update requests. For each granted
//           job it blanks the target row, starts the shared string writer,
//           waits for it to finish and acks the requester. It also owns the OSD
//           character-RAM write port.
// Latency : grant to ack = 1 (GRANT) + COLS (CLEAR) + 1 (START) + writer time + 2.
// Backpr. : START holds while str_busy is high. Requests queue as pending bits,
//           one per source, and the last request wins.
//
// Ports
//   clk, reset            clock, async active-high reset
//   req/req_index/req_row per-source request pulse plus string index and row
//   ack                   per-source done pulse
//   str_start/index/base  command to the string writer
//   str_busy/str_wr_*     writer status and writer RAM write stream
//   osd_wr_*              OSD RAM write port (muxed blank writes / writer writes)
//   busy                  scheduler not idle
module osd_string_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter int          COLS       = 32,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*6-1:0]   req_index,
  input  logic [NUM_REQ*5-1:0]   req_row,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   str_start,
  output logic [5:0]             str_index,
  output logic [10:0]            str_base_addr,
  input  logic                   str_busy,
  input  logic                   str_wr_en,
  input  logic [10:0]            str_wr_addr,
  input  logic [7:0]             str_wr_data,
  output logic                   osd_wr_en,
  output logic [10:0]            osd_wr_addr,
  output logic [7:0]             osd_wr_data,
  output logic                   busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CLEAR,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_ACK
  } state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] pending;
  logic [5:0]         pend_index [NUM_REQ];
  logic [4:0]         pend_row   [NUM_REQ];

  // rr_ptr is the first source considered on the next arbitration; it is
  // last_grant+1 once anything has been served and 0 out of reset.
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      arb_grant;
  logic [GW-1:0]      arb_sel;
  logic               arb_found;

  logic [5:0]         job_index;
  logic [4:0]         job_row;
  logic [10:0]        col;
  logic [10:0]        row_base;

  // Row base is deliberately truncated to the 11-bit RAM address space.
  assign row_base = 11'(32'(job_row) * 32'(COLS));

  // --------------------------------------------------------------------------
  // Round-robin arbiter: scan from rr_ptr; walking the offsets downwards lets
  // the smallest offset with a pending bit be the final assignment.
  // --------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    arb_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_sel = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (pending[arb_sel]) begin
        arb_found = 1'b1;
        arb_grant = arb_sel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arb_found)              state_nxt = S_GRANT;
      S_GRANT:                               state_nxt = S_CLEAR;
      S_CLEAR:   if (col == 11'(COLS - 1))   state_nxt = S_START;
      S_START:   if (!str_busy)              state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (str_busy)               state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!str_busy)              state_nxt = S_ACK;
      S_ACK:                                 state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, job registers and column counter.
  // The pending bit of the granted source is dropped when the job is copied
  // out in GRANT, so any request arriving afterwards (including one in the ACK
  // cycle) leaves the bit set and the source is served again.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      job_index <= '0;
      job_row   <= '0;
      col       <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_index[i] <= '0;
        pend_row[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          pending[i]    <= 1'b1;
          pend_index[i] <= req_index[i*6 +: 6];
          pend_row[i]   <= req_row[i*5 +: 5];
        end else if (state == S_GRANT && grant == GW'(i)) begin
          pending[i]    <= 1'b0;
        end
      end

      if (state == S_IDLE && arb_found) begin
        grant <= arb_grant;
      end

      if (state == S_GRANT) begin
        job_index <= pend_index[grant];
        job_row   <= pend_row[grant];
        col       <= '0;
      end else if (state == S_CLEAR) begin
        col <= col + 11'd1;
      end

      if (state == S_ACK) begin
        rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // Blank writes come straight from the job/column registers; outside CLEAR
  // the writer owns the RAM port and is passed through unregistered.
  // --------------------------------------------------------------------------
  always_comb begin
    busy          = (state != S_IDLE);
    str_start     = (state == S_START) && !str_busy;
    str_index     = job_index;
    str_base_addr = row_base;

    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == S_ACK) && (grant == GW'(i));
    end

    if (state == S_CLEAR) begin
      osd_wr_en   = 1'b1;
      osd_wr_addr = row_base + col;
      osd_wr_data = BLANK_CHAR;
    end else begin
      osd_wr_en   = str_wr_en;
      osd_wr_addr = str_wr_addr;
      osd_wr_data = str_wr_data;
    end
  end

endmodule

// File: tb/tb_osd_string_scheduler.sv
// Testbench for osd_string_scheduler: scoreboard of expected OSD RAM writes and
// acks filled when a request is driven and drained by a negedge monitor, plus
// a behavioural string writer (busy, then one write every 3 cycles per char).
module tb_osd_string_scheduler;

  localparam int NR   = 4;
  localparam int COLS = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR*6-1:0] req_index;
  logic [NR*5-1:0] req_row;
  logic [NR-1:0] ack;
  logic          str_start;
  logic [5:0]    str_index;
  logic [10:0]   str_base_addr;
  logic          str_busy;
  logic          str_wr_en;
  logic [10:0]   str_wr_addr;
  logic [7:0]    str_wr_data;
  logic          osd_wr_en;
  logic [10:0]   osd_wr_addr;
  logic [7:0]    osd_wr_data;
  logic          busy;

  // writer model state
  logic          w_busy, w_wr_en, force_busy;
  logic [10:0]   w_addr;
  logic [7:0]    w_data;

  // The writer model is held quiet while reset is asserted.
  assign str_busy    = (w_busy | force_busy) & ~reset;
  assign str_wr_en   = w_wr_en & ~reset;
  assign str_wr_addr = reset ? 11'd0 : w_addr;
  assign str_wr_data = reset ? 8'd0 : w_data;

  always #5 clk = ~clk;

  osd_string_scheduler #(.NUM_REQ(NR), .COLS(COLS), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .req(req), .req_index(req_index), .req_row(req_row),
    .ack(ack), .str_start(str_start), .str_index(str_index), .str_base_addr(str_base_addr),
    .str_busy(str_busy), .str_wr_en(str_wr_en), .str_wr_addr(str_wr_addr),
    .str_wr_data(str_wr_data), .osd_wr_en(osd_wr_en), .osd_wr_addr(osd_wr_addr),
    .osd_wr_data(osd_wr_data), .busy(busy)
  );

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [NR-1:0] exp_ack[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            start_cycles = 0;

  function automatic string str_of(input int idx);
    case (idx)
      16:      return "None";
      36:      return "55Hz";
      37:      return "50Hz";
      23:      return "";
      default: return "Xy";
    endcase
  endfunction

  // Expected traffic for one job: blank the row, the string, then the ack.
  task automatic push_job(input int src, input int idx, input int row);
    wr_t   w;
    string s;
    for (int c = 0; c < COLS; c++) begin
      w.a = 11'(row * COLS + c);
      w.d = 8'h20;
      exp_wr.push_back(w);
    end
    s = str_of(idx);
    for (int i = 0; i < s.len(); i++) begin
      w.a = 11'(row * COLS + i);
      w.d = 8'(s[i]);
      exp_wr.push_back(w);
    end
    exp_ack.push_back(NR'(1 << src));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NR-1:0] mask, input logic [NR*6-1:0] idxs,
                           input logic [NR*5-1:0] rows);
    req       = mask;
    req_index = idxs;
    req_row   = rows;
    step();
    req       = '0;
  endtask

  task automatic drive_one(input int src, input int idx, input int row);
    drive_req(NR'(1 << src), (NR*6)'(idx) << (src * 6), (NR*5)'(row) << (src * 5));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0;
    force_busy = 1'b0;
    repeat (3) step();
    exp_wr.delete();
    exp_ack.delete();
    start_cycles = 0;
    reset = 1'b0;
    step();
  endtask

  // Waits until the scoreboard is empty and the DUT is idle; reports via done.
  task automatic wait_idle(input int budget, output bit done);
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (exp_wr.size() == 0 && exp_ack.size() == 0 && busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- string writer model ----------------
  initial begin : writer
    int    phase;
    int    ci;
    bit    saw;
    string cur;
    logic [10:0] base;
    w_busy = 1'b0; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    phase = 0; ci = 0; base = '0; cur = "";
    forever begin
      @(negedge clk);
      saw = (str_start === 1'b1) && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        phase = 0; w_busy = 1'b0; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
      end else begin
        case (phase)
          0: if (saw) begin
               cur = str_of(int'(str_index));
               base = str_base_addr;
               ci = 0;
               w_busy = 1'b1;
               phase = (cur.len() == 0) ? 9 : 2;
             end
          2: begin
               w_wr_en = 1'b1; w_addr = base + 11'(ci); w_data = 8'(cur[ci]);
               phase = 3;
             end
          3: begin
               w_wr_en = 1'b0; w_addr = '0; w_data = '0;
               phase = 4;
             end
          4: begin
               ci++;
               phase = (ci == cur.len()) ? 9 : 2;
             end
          default: begin
               w_busy = 1'b0;
               phase = 0;
             end
        endcase
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    wr_t           e;
    logic [NR-1:0] ea;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (osd_wr_en === 1'b1) begin
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL osd_write: unexpected write addr %0d data %h, none required", osd_wr_addr, osd_wr_data);
          end else begin
            e = exp_wr.pop_front();
            if (osd_wr_addr !== e.a || osd_wr_data !== e.d) begin
              n_fail++;
              $display("FAIL osd_write: got addr %0d data %h, required addr %0d data %h", osd_wr_addr, osd_wr_data, e.a, e.d);
            end
          end
        end
        if (ack !== '0) begin
          n_checks++;
          if (exp_ack.size() == 0) begin
            n_fail++;
            $display("FAIL ack: unexpected ack %b, none required", ack);
          end else begin
            ea = exp_ack.pop_front();
            if (ack !== ea) begin
              n_fail++;
              $display("FAIL ack: got %b, required %b", ack, ea);
            end
          end
        end
        if (str_start === 1'b1) start_cycles++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_index = '0; req_row = '0; force_busy = 1'b0;
    repeat (3) step();
    n_checks++; if (ack !== '0)           begin n_fail++; $display("FAIL reset_ack: got %b, required 0", ack); end
    n_checks++; if (str_start !== 1'b0)   begin n_fail++; $display("FAIL reset_str_start: got %b, required 0", str_start); end
    n_checks++; if (str_index !== 6'd0)   begin n_fail++; $display("FAIL reset_str_index: got %0d, required 0", str_index); end
    n_checks++; if (str_base_addr !== 11'd0) begin n_fail++; $display("FAIL reset_str_base: got %0d, required 0", str_base_addr); end
    n_checks++; if (osd_wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_osd_wr_en: got %b, required 0", osd_wr_en); end
    n_checks++; if (osd_wr_addr !== 11'd0) begin n_fail++; $display("FAIL reset_osd_wr_addr: got %0d, required 0", osd_wr_addr); end
    n_checks++; if (osd_wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_osd_wr_data: got %h, required 0", osd_wr_data); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    bit done;
    apply_reset();
    push_job(0, 16, 2);
    drive_one(0, 16, 2);
    wait_idle(300, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL single_job_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
    n_checks++; if (str_index !== 6'd16) begin n_fail++; $display("FAIL single_job_str_index: got %0d, required 16", str_index); end
    n_checks++; if (str_base_addr !== 11'd64) begin n_fail++; $display("FAIL single_job_base: got %0d, required 64", str_base_addr); end
    repeat (5) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_job_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_simultaneous();
    bit done;
    apply_reset();
    // Out of reset the scan starts at source 0.
    push_job(0, 10, 0);
    push_job(1, 11, 1);
    push_job(3, 13, 3);
    drive_req(4'b1011, {6'd13, 6'd0, 6'd11, 6'd10}, {5'd3, 5'd0, 5'd1, 5'd0});
    wait_idle(600, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL simultaneous_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
    // Last grant was 3, so the scan wraps to source 0 first.
    push_job(0, 12, 8);
    push_job(1, 14, 9);
    drive_req(4'b0011, {6'd0, 6'd0, 6'd14, 6'd12}, {5'd0, 5'd0, 5'd9, 5'd8});
    wait_idle(400, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL rr_pair_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
  endtask

  task automatic test_rerequest();
    bit done;
    apply_reset();
    push_job(2, 36, 5);
    push_job(2, 37, 5);
    drive_one(2, 36, 5);
    repeat (6) step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rereq_midjob_busy: got %b, required 1", busy); end
    drive_one(2, 37, 5);
    wait_idle(400, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL rereq_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
  endtask

  task automatic test_writer_busy();
    bit done;
    apply_reset();
    force_busy = 1'b1;
    push_job(1, 16, 4);
    drive_one(1, 16, 4);
    repeat (45) step();
    n_checks++; if (start_cycles != 0) begin n_fail++; $display("FAIL busy_hold_start: got %0d start cycles, required 0", start_cycles); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold_waiting: got busy %b, required 1", busy); end
    force_busy = 1'b0;
    wait_idle(200, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL busy_hold_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
    n_checks++; if (start_cycles != 1) begin n_fail++; $display("FAIL busy_hold_single_start: got %0d start cycles, required 1", start_cycles); end
  endtask

  task automatic test_reset_midop();
    bit done;
    bit seen;
    apply_reset();
    push_job(1, 16, 3);
    drive_one(1, 16, 3);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (str_wr_en === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midop_reach_wait_lo: got no writer write, required one"); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (ack !== '0)         begin n_fail++; $display("FAIL midop_ack: got %b, required 0", ack); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midop_busy: got %b, required 0", busy); end
    n_checks++; if (osd_wr_en !== 1'b0) begin n_fail++; $display("FAIL midop_osd_wr_en: got %b, required 0", osd_wr_en); end
    n_checks++; if (str_index !== 6'd0 || str_base_addr !== 11'd0) begin
      n_fail++; $display("FAIL midop_str_cmd: got index %0d base %0d, required 0 0", str_index, str_base_addr);
    end
    exp_wr.delete();
    exp_ack.delete();
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_pending_dropped: got busy %b, required 0", busy); end
    push_job(3, 36, 1);
    drive_one(3, 36, 1);
    wait_idle(300, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL midop_recover_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
  endtask

  task automatic test_empty_string();
    bit done;
    apply_reset();
    push_job(2, 23, 7);
    drive_one(2, 23, 7);
    wait_idle(200, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL empty_drain: got %0d writes/%0d acks left, required 0/0", exp_wr.size(), exp_ack.size()); end
    repeat (5) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_after: got %b, required 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_index = '0; req_row = '0; force_busy = 1'b0;
    test_reset();
    test_single_job();
    test_simultaneous();
    test_rerequest();
    test_writer_busy();
    test_reset_midop();
    test_empty_string();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
